// File: rtl/classifier_pkg.sv
// Shared definitions for the event classifier and its configuration sequencer.
// Holds the classifier event encodings, the configuration command opcodes,
// the READ selector codes, the reset defaults of the classifier settings and
// the commit validation rule.
package classifier_pkg;

    // Classifier event_out encodings
    localparam logic [1:0] EVENT_C = 2'b00;
    localparam logic [1:0] EVENT_B = 2'b01;
    localparam logic [1:0] EVENT_A = 2'b10;

    // Command opcodes (first byte of every command)
    localparam logic [7:0] OP_WR_A    = 8'h01;
    localparam logic [7:0] OP_WR_B    = 8'h02;
    localparam logic [7:0] OP_WR_TO   = 8'h03;
    localparam logic [7:0] OP_COMMIT  = 8'h04;
    localparam logic [7:0] OP_READ    = 8'h05;
    localparam logic [7:0] OP_CLR_ERR = 8'h06;

    // READ selector codes
    localparam logic [7:0] SEL_ACT_A    = 8'd0;
    localparam logic [7:0] SEL_ACT_B    = 8'd1;
    localparam logic [7:0] SEL_ACT_TO_H = 8'd2;
    localparam logic [7:0] SEL_ACT_TO_L = 8'd3;
    localparam logic [7:0] SEL_STATUS   = 8'd4;

    // Reset defaults and limits
    localparam logic [7:0]  DEF_A_THRESH = 8'd5;
    localparam logic [7:0]  DEF_B_THRESH = 8'd1;
    localparam logic [15:0] DEF_TIMEOUT  = 16'd10000;
    localparam logic [15:0] MIN_TIMEOUT  = 16'd16;
    localparam int          MAX_DEFER    = 4000;
    localparam int          DEFER_W      = $clog2(MAX_DEFER + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAY1,
        ST_PAY2,
        ST_WAIT_SAFE
    } cfg_state_e;

    // A staged setting is only usable if class A is strictly harder to reach
    // than class B and the timeout is not unreasonably short.
    function automatic logic cfgSetValid(input logic [7:0]  threshA,
                                         input logic [7:0]  threshB,
                                         input logic [15:0] timeout);
        return (threshA > threshB) && (timeout >= MIN_TIMEOUT);
    endfunction

endpackage

// File: rtl/classifier_cfg_ctrl.sv
// Configuration sequencer for the event classifier.
// Parses a byte-serial command stream, stages threshold/timeout values in
// shadow registers and applies them atomically to the classifier once it
// reports EVENT_C, or after a bounded deferral.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   cfg_valid/data  - command/payload byte stream in
//   cfg_ready       - low only while a commit waits for a safe point
//   event_in        - classifier event_out
//   class_a_thresh, class_b_thresh, timeout_period - active settings out
//   commit_pending  - commit accepted, not yet applied
//   cfg_err         - sticky error flag, cleared by CLR_ERR
//   rd_valid/rd_data - one-cycle readback strobe and byte
module classifier_cfg_ctrl
    import classifier_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_valid,
    input  logic [7:0]  cfg_data,
    output logic        cfg_ready,
    input  logic [1:0]  event_in,
    output logic [7:0]  class_a_thresh,
    output logic [7:0]  class_b_thresh,
    output logic [15:0] timeout_period,
    output logic        commit_pending,
    output logic        cfg_err,
    output logic        rd_valid,
    output logic [7:0]  rd_data
);

    localparam logic [DEFER_W-1:0] DEFER_LAST = DEFER_W'(MAX_DEFER - 1);

    cfg_state_e         state_q, state_d;
    logic [7:0]         op_q, op_d;
    logic [7:0]         msb_q, msb_d;
    logic [7:0]         shA_q, shA_d, shB_q, shB_d;
    logic [15:0]        shTo_q, shTo_d;
    logic [7:0]         actA_q, actA_d, actB_q, actB_d;
    logic [15:0]        actTo_q, actTo_d;
    logic               err_q, err_d;
    logic               rdValid_q, rdValid_d;
    logic [7:0]         rdData_q, rdData_d;
    logic [DEFER_W-1:0] defer_q, defer_d;
    logic               handshake;

    assign cfg_ready      = (state_q != ST_WAIT_SAFE);
    assign commit_pending = (state_q == ST_WAIT_SAFE);
    assign handshake      = cfg_valid && cfg_ready;

    assign class_a_thresh = actA_q;
    assign class_b_thresh = actB_q;
    assign timeout_period = actTo_q;
    assign cfg_err        = err_q;
    assign rd_valid       = rdValid_q;
    assign rd_data        = rdData_q;

    // All state, including shadow contents and any partial command, is
    // discarded by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= 8'h00;
            msb_q     <= 8'h00;
            shA_q     <= DEF_A_THRESH;
            shB_q     <= DEF_B_THRESH;
            shTo_q    <= DEF_TIMEOUT;
            actA_q    <= DEF_A_THRESH;
            actB_q    <= DEF_B_THRESH;
            actTo_q   <= DEF_TIMEOUT;
            err_q     <= 1'b0;
            rdValid_q <= 1'b0;
            rdData_q  <= 8'h00;
            defer_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            msb_q     <= msb_d;
            shA_q     <= shA_d;
            shB_q     <= shB_d;
            shTo_q    <= shTo_d;
            actA_q    <= actA_d;
            actB_q    <= actB_d;
            actTo_q   <= actTo_d;
            err_q     <= err_d;
            rdValid_q <= rdValid_d;
            rdData_q  <= rdData_d;
            defer_q   <= defer_d;
        end
    end

    // Command parser and commit sequencer. rd_valid defaults low so it can
    // only ever be a single-cycle strobe; rd_data holds its last value.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        msb_d     = msb_q;
        shA_d     = shA_q;
        shB_d     = shB_q;
        shTo_d    = shTo_q;
        actA_d    = actA_q;
        actB_d    = actB_q;
        actTo_d   = actTo_q;
        err_d     = err_q;
        rdValid_d = 1'b0;
        rdData_d  = rdData_q;
        defer_d   = defer_q;

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    case (cfg_data)
                        OP_WR_A, OP_WR_B, OP_WR_TO, OP_READ: begin
                            op_d    = cfg_data;
                            state_d = ST_PAY1;
                        end
                        OP_COMMIT: begin
                            defer_d = '0;
                            state_d = ST_WAIT_SAFE;
                        end
                        OP_CLR_ERR: err_d = 1'b0;
                        default:    err_d = 1'b1;
                    endcase
                end
            end

            ST_PAY1: begin
                if (handshake) begin
                    state_d = ST_IDLE;
                    case (op_q)
                        OP_WR_A: shA_d = cfg_data;
                        OP_WR_B: shB_d = cfg_data;
                        OP_WR_TO: begin
                            msb_d   = cfg_data;
                            state_d = ST_PAY2;
                        end
                        OP_READ: begin
                            rdValid_d = 1'b1;
                            case (cfg_data)
                                SEL_ACT_A:    rdData_d = actA_q;
                                SEL_ACT_B:    rdData_d = actB_q;
                                SEL_ACT_TO_H: rdData_d = actTo_q[15:8];
                                SEL_ACT_TO_L: rdData_d = actTo_q[7:0];
                                SEL_STATUS:   rdData_d = {6'b0, err_q, commit_pending};
                                default: begin
                                    rdData_d = 8'hFF;
                                    err_d    = 1'b1;
                                end
                            endcase
                        end
                        default: ;
                    endcase
                end
            end

            ST_PAY2: begin
                if (handshake) begin
                    shTo_d  = {msb_q, cfg_data};
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT_SAFE: begin
                // Apply on a quiet classifier, or force it once the deferral
                // budget is spent so a busy input cannot starve the commit.
                if ((event_in == EVENT_C) || (defer_q >= DEFER_LAST)) begin
                    if (cfgSetValid(shA_q, shB_q, shTo_q)) begin
                        actA_d  = shA_q;
                        actB_d  = shB_q;
                        actTo_d = shTo_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    defer_d = '0;
                    state_d = ST_IDLE;
                end else if (defer_q != {DEFER_W{1'b1}}) begin
                    defer_d = defer_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_classifier_cfg_ctrl.sv
// Self-checking testbench for classifier_cfg_ctrl.
// A command-level model (byte queue per command) predicts every output and is
// compared on each falling edge; directed literal checks pin the model.
module tb_classifier_cfg_ctrl;

    localparam int MODEL_MAX_DEFER = 4000;

    logic        clk;
    logic        reset;
    logic        cfg_valid;
    logic [7:0]  cfg_data;
    logic        cfg_ready;
    logic [1:0]  event_in;
    logic [7:0]  class_a_thresh;
    logic [7:0]  class_b_thresh;
    logic [15:0] timeout_period;
    logic        commit_pending;
    logic        cfg_err;
    logic        rd_valid;
    logic [7:0]  rd_data;

    int checkCount = 0;
    int errorCount = 0;

    classifier_cfg_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_data       (cfg_data),
        .cfg_ready      (cfg_ready),
        .event_in       (event_in),
        .class_a_thresh (class_a_thresh),
        .class_b_thresh (class_b_thresh),
        .timeout_period (timeout_period),
        .commit_pending (commit_pending),
        .cfg_err        (cfg_err),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison helper shared by the model compare and the directed checks
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------
    // Command-level model: bytes are gathered per command and acted on when
    // the command is complete; a commit waits for EVENT_C or the deferral
    // budget expressed as a plain count of waiting cycles.
    // ------------------------------------------------------------------
    logic [7:0]  mShA, mShB, mActA, mActB;
    logic [15:0] mShTo, mActTo;
    logic        mErr, mWaiting, mRdv;
    logic [7:0]  mRdd;
    int          mWaitCycles;
    logic [7:0]  cmdBytes[$];

    function automatic int cmdLen(input logic [7:0] op);
        case (op)
            8'h01, 8'h02, 8'h05: return 2;
            8'h03:               return 3;
            default:             return 1;
        endcase
    endfunction

    task automatic modelReset();
        mShA = 8'd5;  mShB = 8'd1;  mShTo = 16'd10000;
        mActA = 8'd5; mActB = 8'd1; mActTo = 16'd10000;
        mErr = 1'b0; mWaiting = 1'b0; mRdv = 1'b0; mRdd = 8'h00;
        mWaitCycles = 0;
        cmdBytes.delete();
    endtask

    task automatic modelExecute();
        logic [7:0] op;
        op = cmdBytes[0];
        case (op)
            8'h01: mShA = cmdBytes[1];
            8'h02: mShB = cmdBytes[1];
            8'h03: mShTo = {cmdBytes[1], cmdBytes[2]};
            8'h04: begin
                mWaiting    = 1'b1;
                mWaitCycles = 0;
            end
            8'h05: begin
                mRdv = 1'b1;
                case (cmdBytes[1])
                    8'd0: mRdd = mActA;
                    8'd1: mRdd = mActB;
                    8'd2: mRdd = mActTo / 256;
                    8'd3: mRdd = mActTo % 256;
                    8'd4: mRdd = mErr ? 8'd2 : 8'd0;
                    default: begin
                        mRdd = 8'hFF;
                        mErr = 1'b1;
                    end
                endcase
            end
            8'h06: mErr = 1'b0;
            default: mErr = 1'b1;
        endcase
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            modelReset();
        end else begin
            mRdv = 1'b0;
            if (mWaiting) begin
                mWaitCycles++;
                if (event_in == 2'b00 || mWaitCycles == MODEL_MAX_DEFER) begin
                    if (mShA > mShB && mShTo >= 16) begin
                        mActA  = mShA;
                        mActB  = mShB;
                        mActTo = mShTo;
                    end else begin
                        mErr = 1'b1;
                    end
                    mWaiting = 1'b0;
                end
            end else if (cfg_valid) begin
                cmdBytes.push_back(cfg_data);
                if (cmdBytes.size() == cmdLen(cmdBytes[0])) begin
                    modelExecute();
                    cmdBytes.delete();
                end
            end
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("mdl_class_a", 32'(class_a_thresh), 32'(mActA));
            checkOutput("mdl_class_b", 32'(class_b_thresh), 32'(mActB));
            checkOutput("mdl_timeout", 32'(timeout_period), 32'(mActTo));
            checkOutput("mdl_cfg_ready", 32'(cfg_ready), 32'(!mWaiting));
            checkOutput("mdl_commit_pending", 32'(commit_pending), 32'(mWaiting));
            checkOutput("mdl_cfg_err", 32'(cfg_err), 32'(mErr));
            checkOutput("mdl_rd_valid", 32'(rd_valid), 32'(mRdv));
            if (mRdv) checkOutput("mdl_rd_data", 32'(rd_data), 32'(mRdd));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; all called at posedge+1 and return at posedge+1
    // ------------------------------------------------------------------
    task automatic applyStimulus(input logic [7:0] b);
        bit done;
        done      = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = b;
        for (int i = 0; i < 5000 && !done; i++) begin
            if (cfg_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        cfg_valid = 1'b0;
        if (!done) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL handshake_timeout byte=%0h ready=%0b required=1", b, cfg_ready);
        end
    endtask

    task automatic resetDut();
        cfg_valid = 1'b0;
        reset     = 1'b1;
        #3;
        reset     = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic readSel(input logic [7:0] sel, input logic [7:0] expected, input string name);
        applyStimulus(8'h05);
        applyStimulus(sel);
        checkOutput({name, "_valid"}, 32'(rd_valid), 32'd1);
        checkOutput(name, 32'(rd_data), 32'(expected));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        event_in  = 2'b00;
        #12;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset values
        checkOutput("rst_class_a", 32'(class_a_thresh), 32'd5);
        checkOutput("rst_class_b", 32'(class_b_thresh), 32'd1);
        checkOutput("rst_timeout", 32'(timeout_period), 32'd10000);
        checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("rst_cfg_err", 32'(cfg_err), 32'd0);
        checkOutput("rst_commit_pending", 32'(commit_pending), 32'd0);
        checkOutput("rst_rd_data", 32'(rd_data), 32'd0);

        // Immediate apply with EVENT_C present
        applyStimulus(8'h01); applyStimulus(8'h08);
        applyStimulus(8'h02); applyStimulus(8'h03);
        applyStimulus(8'h03); applyStimulus(8'h01); applyStimulus(8'hF4);
        checkOutput("shadow_no_effect_a", 32'(class_a_thresh), 32'd5);
        applyStimulus(8'h04);
        checkOutput("commit_pending_pulse", 32'(commit_pending), 32'd1);
        checkOutput("commit_ready_low", 32'(cfg_ready), 32'd0);
        checkOutput("commit_not_yet_a", 32'(class_a_thresh), 32'd5);
        @(posedge clk); #1;
        checkOutput("fast_apply_a", 32'(class_a_thresh), 32'd8);
        checkOutput("fast_apply_b", 32'(class_b_thresh), 32'd3);
        checkOutput("fast_apply_to", 32'(timeout_period), 32'd500);
        checkOutput("fast_pending_clear", 32'(commit_pending), 32'd0);

        // Deferred apply: EVENT_A held, then EVENT_C at cycle 50
        event_in = 2'b10;
        applyStimulus(8'h01); applyStimulus(8'h0C);
        applyStimulus(8'h02); applyStimulus(8'h02);
        applyStimulus(8'h03); applyStimulus(8'h03); applyStimulus(8'hE8);
        applyStimulus(8'h04);
        repeat (49) begin @(posedge clk); #1; end
        checkOutput("defer_hold_a", 32'(class_a_thresh), 32'd8);
        checkOutput("defer_ready_low", 32'(cfg_ready), 32'd0);
        event_in = 2'b00;
        @(posedge clk); #1;
        checkOutput("defer_apply_a", 32'(class_a_thresh), 32'd12);
        checkOutput("defer_apply_to", 32'(timeout_period), 32'd1000);

        // Forced apply after the full deferral budget
        event_in = 2'b10;
        applyStimulus(8'h01); applyStimulus(8'h20);
        applyStimulus(8'h04);
        repeat (MODEL_MAX_DEFER - 1) begin @(posedge clk); #1; end
        checkOutput("force_still_pending", 32'(commit_pending), 32'd1);
        checkOutput("force_hold_a", 32'(class_a_thresh), 32'd12);
        @(posedge clk); #1;
        checkOutput("force_applied_a", 32'(class_a_thresh), 32'h20);
        checkOutput("force_pending_clear", 32'(commit_pending), 32'd0);
        event_in = 2'b00;

        // Rejected commit (A <= B), status readback, error clear
        resetDut();
        applyStimulus(8'h01); applyStimulus(8'h02);
        applyStimulus(8'h02); applyStimulus(8'h04);
        applyStimulus(8'h04);
        @(posedge clk); #1;
        checkOutput("reject_ab_a", 32'(class_a_thresh), 32'd5);
        checkOutput("reject_ab_b", 32'(class_b_thresh), 32'd1);
        checkOutput("reject_ab_err", 32'(cfg_err), 32'd1);
        readSel(8'd4, 8'h02, "read_status");
        applyStimulus(8'h06);
        checkOutput("clr_err", 32'(cfg_err), 32'd0);

        // Rejected commit on short timeout, bad opcode, bad selector
        applyStimulus(8'h01); applyStimulus(8'h08);
        applyStimulus(8'h03); applyStimulus(8'h00); applyStimulus(8'h0A);
        applyStimulus(8'h04);
        @(posedge clk); #1;
        checkOutput("reject_to_timeout", 32'(timeout_period), 32'd10000);
        checkOutput("reject_to_err", 32'(cfg_err), 32'd1);
        applyStimulus(8'h06);
        applyStimulus(8'h7F);
        checkOutput("bad_opcode_err", 32'(cfg_err), 32'd1);
        applyStimulus(8'h06);
        readSel(8'd9, 8'hFF, "read_bad_sel");
        checkOutput("bad_sel_err", 32'(cfg_err), 32'd1);
        readSel(8'd0, 8'd5, "read_act_a");
        readSel(8'd1, 8'd1, "read_act_b");

        // Reset in the middle of WR_TO discards the partial command
        applyStimulus(8'h06);
        applyStimulus(8'h03); applyStimulus(8'h12);
        resetDut();
        readSel(8'd2, 8'h27, "read_to_hi");
        readSel(8'd3, 8'h10, "read_to_lo");
        applyStimulus(8'h04);
        @(posedge clk); #1;
        checkOutput("post_reset_commit_to", 32'(timeout_period), 32'd10000);
        checkOutput("post_reset_commit_err", 32'(cfg_err), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
